tt_maquina_input_cond: RTL and testbench

TT_MAQUINA_INPUT_COND -- requirements
Module: tt_maquina_input_cond

---
 rtl/tt_maquina_pkg.sv | 27 ++
 rtl/tt_maquina_debounce.sv | 54 +++++
 rtl/tt_maquina_input_cond.sv | 41 ++++
 tb/tb_tt_maquina_input_cond.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/tt_maquina_pkg.sv
// Shared constants and press-arbitration helpers for the vending-machine input conditioner.
// Channel order on every 4-bit vector is {P,R,N,D}, with D on bit 0.
package tt_maquina_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_D   = 0;
  localparam int CH_N   = 1;
  localparam int CH_R   = 2;
  localparam int CH_P   = 3;

  localparam int DEF_DEBOUNCE_CYCLES = 100000;
  localparam int DEF_CNT_W           = 17;

  // Keep only the lowest set bit, which is the highest-priority press (D wins).
  function automatic logic [NUM_CH-1:0] prio_pick(input logic [NUM_CH-1:0] v);
    logic [NUM_CH-1:0] one;
    one = 1;
    return v & (~v + one);
  endfunction

  function automatic logic multi_hot(input logic [NUM_CH-1:0] v);
    logic [NUM_CH-1:0] one;
    one = 1;
    return (v & (v - one)) != '0;
  endfunction

endpackage

// File: rtl/tt_maquina_debounce.sv
// One conditioner channel: 2-flop synchronizer, hold-time counter, debounced level and a rise pulse.
// The pulse is registered, so it rises on the same edge as the level does.
module tt_maquina_debounce
  import tt_maquina_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Any sample that agrees with the current level restarts the hold count.
  // The count stops at CNT_LAST and never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync2;
        pulse <= sync2;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/tt_maquina_input_cond.sv
// Debounces the four vending-machine buttons {P,R,N,D} and emits one-cycle press pulses.
// Define TT_MAQUINA_PRESS_ARB_EN to keep only the highest-priority press when several qualify at once.
module tt_maquina_input_cond
  import tt_maquina_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] sw_raw,
  output logic [NUM_CH-1:0] sw_pulse,
  output logic [NUM_CH-1:0] sw_level,
  output logic              collision
);

  logic [NUM_CH-1:0] rise;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    tt_maquina_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .clk  (clk),
      .reset(reset),
      .raw  (sw_raw[ch]),
      .level(sw_level[ch]),
      .pulse(rise[ch])
    );
  end

`ifdef TT_MAQUINA_PRESS_ARB_EN
  // Losing presses are dropped for good; their levels still read high.
  assign sw_pulse  = prio_pick(rise);
  assign collision = multi_hot(rise);
`else
  assign sw_pulse  = rise;
  assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_tt_maquina_input_cond.sv
// Randomized and directed bench for tt_maquina_input_cond, using a short debounce window.
// The reference model works from a history of raw samples: a level is accepted once DEBOUNCE_CYCLES synchronized samples agree.
module tb_tt_maquina_input_cond;
  import tt_maquina_pkg::*;

  localparam int DC = 4;
  localparam int CW = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sw_raw;
  logic [3:0] sw_pulse;
  logic [3:0] sw_level;
  logic       collision;

  always #5 clk = ~clk;

  tt_maquina_input_cond #(
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sw_raw   (sw_raw),
    .sw_pulse (sw_pulse),
    .sw_level (sw_level),
    .collision(collision)
  );

  int n_vec = 0;
  int n_err = 0;
  int p2_cnt = 0;

  logic [3:0] exp_level;
  logic [3:0] exp_pulse;
  logic       exp_coll;
  logic [3:0] hist_q[$];
  logic [3:0] exp_q[$];
  logic [3:0] m_rise;
  logic       m_v;
  logic       m_same;
  int         m_n;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model. hist_q holds the last DC+2 raw samples; the two newest are still in the
  // synchronizer, so the older DC samples are the ones the debouncer has already seen.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q.delete();
      for (int i = 0; i < DC + 2; i++) hist_q.push_back(4'b0000);
      exp_level = '0;
      exp_pulse = '0;
      exp_coll  = 1'b0;
      exp_q.delete();
    end else begin
      hist_q.push_back(sw_raw);
      void'(hist_q.pop_front());
      m_rise = '0;
      for (int ch = 0; ch < 4; ch++) begin
        m_v    = hist_q[0][ch];
        m_same = 1'b1;
        for (int k = 1; k < DC; k++) if (hist_q[k][ch] != m_v) m_same = 1'b0;
        if (m_same && (m_v != exp_level[ch])) begin
          exp_level[ch] = m_v;
          if (m_v) m_rise[ch] = 1'b1;
        end
      end
      m_n = $countones(m_rise);
`ifdef TT_MAQUINA_PRESS_ARB_EN
      exp_pulse = m_rise;
      exp_coll  = 1'b0;
      if (m_n > 1) begin
        exp_coll  = 1'b1;
        exp_pulse = '0;
        for (int ch = 3; ch >= 0; ch--) if (m_rise[ch]) exp_pulse = 4'b0001 << ch;
      end
`else
      exp_pulse = m_rise;
      exp_coll  = 1'b0;
`endif
      if (exp_pulse != '0) exp_q.push_back(exp_pulse);
    end
  end

  // Per-cycle comparison plus a scoreboard of emitted pulses.
  always @(negedge clk) begin
    check("level", 32'(sw_level), 32'(exp_level));
    check("pulse", 32'(sw_pulse), 32'(exp_pulse));
    check("collision", 32'(collision), 32'(exp_coll));
    if (sw_pulse != '0) begin
      if (exp_q.size() == 0) check("pulse_unexpected", 32'(sw_pulse), 32'(0));
      else check("pulse_sb", 32'(sw_pulse), 32'(exp_q.pop_front()));
    end
    if (sw_pulse[CH_R]) p2_cnt++;
  end

  task automatic drive_raw(input logic [3:0] v);
    @(negedge clk);
    sw_raw = v;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called right after a drive; counts DUT edges from the first sampling edge.
  task automatic expect_pulse(input string tag, input logic [3:0] vec, input int edges);
    for (int i = 1; i <= edges; i++) begin
      @(negedge clk);
      if (i == edges - 1) check({tag, "_early"}, 32'(sw_pulse), 32'(0));
      if (i == edges) check(tag, 32'(sw_pulse), 32'(vec));
    end
  endtask

  task automatic settle();
    drive_raw(4'b0000);
    wait_cycles(12);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    sw_raw = '0;
    reset  = 1'b0;
    #1 reset = 1'b1;
    #2;
    check("reset_level", 32'(sw_level), 32'(0));
    check("reset_pulse", 32'(sw_pulse), 32'(0));
    check("reset_coll", 32'(collision), 32'(0));
    wait_cycles(2);
    reset = 1'b0;
    wait_cycles(3);

    // Single press on N, held.
    drive_raw(4'b0010);
    expect_pulse("n_press", 4'b0010, 6);
    wait_cycles(5);
    check("n_level_held", 32'(sw_level[CH_N]), 32'(1));
    settle();

    // Bounces shorter than the window on D.
    for (int r = 0; r < 5; r++) begin
      drive_raw(4'b0001);
      wait_cycles(2);
      drive_raw(4'b0000);
      wait_cycles(2);
    end
    wait_cycles(8);
    check("d_bounce_level", 32'(sw_level[CH_D]), 32'(0));
    settle();

    // Reset in the middle of a debounce on P, then P held through release.
    drive_raw(4'b1000);
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_level", 32'(sw_level), 32'(0));
    check("midrst_pulse", 32'(sw_pulse), 32'(0));
    check("midrst_coll", 32'(collision), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    expect_pulse("p_after_rst", 4'b1000, 6);
    settle();

    // P and D qualify together.
    drive_raw(4'b1001);
`ifdef TT_MAQUINA_PRESS_ARB_EN
    expect_pulse("pd_arb", 4'b0001, 6);
    check("pd_collision", 32'(collision), 32'(1));
`else
    expect_pulse("pd_noarb", 4'b1001, 6);
    check("pd_collision", 32'(collision), 32'(0));
`endif
    wait_cycles(1);
    check("pd_levels", 32'(sw_level), 32'(4'b1001));
    settle();

    // Long hold on R, release, press again.
    p2_cnt = 0;
    drive_raw(4'b0100);
    wait_cycles(1000);
    drive_raw(4'b0000);
    wait_cycles(20);
    drive_raw(4'b0100);
    wait_cycles(20);
    drive_raw(4'b0000);
    wait_cycles(20);
    check("r_pulse_count", 32'(p2_cnt), 32'(2));

    // Random bouncing on all channels with a varying toggle rate.
    for (int seg = 0; seg < 20; seg++) begin
      int rate;
      rate = $urandom_range(2, 12);
      for (int c = 0; c < 100; c++) begin
        logic [3:0] nv;
        nv = sw_raw;
        for (int ch = 0; ch < 4; ch++)
          if ($urandom_range(0, rate) == 0) nv[ch] = ~nv[ch];
        drive_raw(nv);
      end
    end
    settle();

    check("sb_drain", 32'(exp_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
